// File: rtl/snake_renderer.sv
// Two-stage pixel pipeline for the snake board: maps the raster position to a board RAM
// address, then turns the returned cell code into a colour aligned with the delayed syncs.
module snake_renderer #(
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_pix_tick,
  input  logic [9:0]  i_hcount,
  input  logic [9:0]  i_vcount,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_video_on,
  input  logic        i_game_over,
  output logic [10:0] o_cell_addr,
  input  logic [1:0]  i_cell_data,
  output logic [11:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_start,
  output logic [5:0]  o_frame_cnt
);

  localparam logic [11:0] ColBlack  = 12'h000;
  localparam logic [11:0] ColBorder = 12'h888;
  localparam logic [11:0] ColBody   = 12'h0F0;
  localparam logic [11:0] ColHead   = 12'hFF0;
  localparam logic [11:0] ColRed    = 12'hF00;
  localparam logic [11:0] ColDead   = 12'hF0F;

  localparam logic [1:0] CellEmpty = 2'd0;
  localparam logic [1:0] CellBody  = 2'd1;
  localparam logic [1:0] CellHead  = 2'd2;
  localparam logic [1:0] CellFood  = 2'd3;

  logic [9:0]  w_col;
  logic [9:0]  w_row;
  logic [10:0] w_addr;
  logic        w_edge;
  logic        w_frame_hit;
  logic [11:0] w_bg;
  logic [11:0] w_rgb;

  // Stage 1 state
  logic [10:0] r_cell_addr;
  logic        r_vid1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_edge1;

  // Stage 2 state
  logic [11:0] r_rgb;
  logic        r_hs2;
  logic        r_vs2;

  logic        r_frame_start;
  logic [5:0]  r_frame_cnt;

  assign w_col  = i_hcount >> CELL_SHIFT;
  assign w_row  = i_vcount >> CELL_SHIFT;
  assign w_addr = 11'(w_row) * 11'(GRID_W) + 11'(w_col);

  assign w_edge = (w_row == 10'd0) || (w_row == 10'(GRID_H - 1)) ||
                  (w_col == 10'd0) || (w_col == 10'(GRID_W - 1));

  assign w_frame_hit = i_pix_tick && (i_hcount == 10'd0) && (i_vcount == 10'd0);

  // Empty cells show the border colour on the outer ring of the grid
  assign w_bg = r_edge1 ? ColBorder : ColBlack;

  always_comb begin
    w_rgb = ColBlack;
    if (r_vid1) begin
      unique case (i_cell_data)
        CellEmpty: w_rgb = w_bg;
        CellBody:  w_rgb = i_game_over ? ColRed  : ColBody;
        CellHead:  w_rgb = i_game_over ? ColDead : ColHead;
        CellFood:  w_rgb = r_frame_cnt[4] ? w_bg : ColRed;
        default:   w_rgb = ColBlack;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cell_addr   <= '0;
      r_vid1        <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
      r_edge1       <= 1'b0;
      r_rgb         <= ColBlack;
      r_hs2         <= 1'b1;
      r_vs2         <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_start <= w_frame_hit;
      if (w_frame_hit) begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
      if (i_pix_tick) begin
        r_cell_addr <= i_video_on ? w_addr : 11'd0;
        r_vid1      <= i_video_on;
        r_hs1       <= i_hsync;
        r_vs1       <= i_vsync;
        r_edge1     <= w_edge;
        r_rgb       <= w_rgb;
        r_hs2       <= r_hs1;
        r_vs2       <= r_vs1;
      end
    end
  end

  assign o_cell_addr   = r_cell_addr;
  assign o_rgb         = r_rgb;
  assign o_hsync       = r_hs2;
  assign o_vsync       = r_vs2;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_snake_renderer.sv
// Directed bench for snake_renderer: the bench plays the board RAM by driving i_cell_data
// for the address presented one pixel tick earlier.
module tb_snake_renderer;

  logic        clk;
  logic        resetn;
  logic        pix_tick;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        game_over;
  logic [10:0] cell_addr;
  logic [1:0]  cell_data;
  logic [11:0] rgb;
  logic        hsync_o;
  logic        vsync_o;
  logic        frame_start;
  logic [5:0]  frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  snake_renderer dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_pix_tick   (pix_tick),
    .i_hcount     (hcount),
    .i_vcount     (vcount),
    .i_hsync      (hsync),
    .i_vsync      (vsync),
    .i_video_on   (video_on),
    .i_game_over  (game_over),
    .o_cell_addr  (cell_addr),
    .i_cell_data  (cell_data),
    .o_rgb        (rgb),
    .o_hsync      (hsync_o),
    .o_vsync      (vsync_o),
    .o_frame_start(frame_start),
    .o_frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel tick; returns #1 after the enabled edge with pix_tick already dropped.
  task automatic tick();
    repeat (3) @(posedge clk);
    @(negedge clk);
    pix_tick = 1'b1;
    @(posedge clk);
    #1;
    pix_tick = 1'b0;
  endtask

  task automatic set_pix(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
  endtask

  task automatic frame_tick();
    set_pix(0, 0);
    tick();
    exp_cnt = (exp_cnt + 1) % 64;
    set_pix(100, 100);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rgb"},   rgb, 12'h000);
    chk({tag, "_hs"},    {11'd0, hsync_o}, 12'd1);
    chk({tag, "_vs"},    {11'd0, vsync_o}, 12'd1);
    chk({tag, "_addr"},  {1'b0, cell_addr}, 12'd0);
    chk({tag, "_fs"},    {11'd0, frame_start}, 12'd0);
    chk({tag, "_cnt"},   {6'd0, frame_cnt}, 12'd0);
  endtask

  initial begin
    resetn    = 1'b0;
    pix_tick  = 1'b0;
    hsync     = 1'b1;
    vsync     = 1'b1;
    video_on  = 1'b0;
    game_over = 1'b0;
    cell_data = 2'd0;
    set_pix(100, 100);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    resetn = 1'b1;

    // Pixel (17,33): cell (1,2) -> address 81, body colour two ticks later
    video_on = 1'b1;
    set_pix(17, 33);
    tick();
    chk("addr_81", {1'b0, cell_addr}, 12'd81);
    cell_data = 2'd1;
    tick();
    chk("body_rgb", rgb, 12'h0F0);

    // Frame start at (0,0) with an empty edge cell
    cell_data = 2'd0;
    frame_tick();
    exp_cnt = 1;
    chk("fs_pulse", {11'd0, frame_start}, 12'd1);
    chk("cnt_1", {6'd0, frame_cnt}, 12'd1);
    chk("addr_0", {1'b0, cell_addr}, 12'd0);
    @(posedge clk);
    #1;
    chk("fs_single", {11'd0, frame_start}, 12'd0);
    tick();
    chk("edge_rgb", rgb, 12'h888);

    // Food at cell (5,5) blinks on frame_cnt[4]
    cell_data = 2'd3;
    for (int f = 0; f < 32; f++) begin
      frame_tick();
      set_pix(80, 80);
      tick();
      tick();
      chk("food_blink", rgb, ((exp_cnt >> 4) & 1) != 0 ? 12'h000 : 12'hF00);
    end
    chk("food_addr", {1'b0, cell_addr}, 12'd205);
    chk("cnt_33", {6'd0, frame_cnt}, 12'(exp_cnt));

    // Game-over colours and blanking
    game_over = 1'b1;
    cell_data = 2'd2;
    tick();
    tick();
    chk("go_head", rgb, 12'hF0F);
    cell_data = 2'd1;
    tick();
    chk("go_body", rgb, 12'hF00);
    cell_data = 2'd2;
    video_on  = 1'b0;
    set_pix(700, 600);
    tick();
    chk("blank_addr", {1'b0, cell_addr}, 12'd0);
    tick();
    chk("blank_rgb", rgb, 12'h000);
    game_over = 1'b0;
    video_on  = 1'b1;
    set_pix(80, 80);
    tick();
    tick();
    chk("head_rgb", rgb, 12'hFF0);

    // Sync delay: low at tick N seen after tick N+1
    cell_data = 2'd1;
    hsync = 1'b0;
    tick();
    chk("hs_n1", {11'd0, hsync_o}, 12'd1);
    hsync = 1'b1;
    vsync = 1'b0;
    tick();
    chk("hs_n2", {11'd0, hsync_o}, 12'd0);
    chk("vs_n2", {11'd0, vsync_o}, 12'd1);
    vsync = 1'b1;
    tick();
    chk("vs_n3", {11'd0, vsync_o}, 12'd0);
    chk("hold_pre_rgb", rgb, 12'h0F0);

    // pix_tick held low: nothing moves even with (0,0) on the inputs
    cell_data = 2'd3;
    hsync = 1'b0;
    set_pix(0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("hold_rgb", rgb, 12'h0F0);
    chk("hold_hs", {11'd0, hsync_o}, 12'd1);
    chk("hold_vs", {11'd0, vsync_o}, 12'd0);
    chk("hold_addr", {1'b0, cell_addr}, 12'd205);
    chk("hold_fs", {11'd0, frame_start}, 12'd0);
    chk("hold_cnt", {6'd0, frame_cnt}, 12'(exp_cnt));
    hsync = 1'b1;

    // Count to 37, then reset mid-frame without a pixel tick
    while (exp_cnt != 37) frame_tick();
    chk("cnt_37", {6'd0, frame_cnt}, 12'd37);
    set_pix(80, 80);
    tick();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("midreset");
    resetn  = 1'b1;
    exp_cnt = 0;

    // Wrap 63 -> 0
    cell_data = 2'd0;
    while (exp_cnt != 63) frame_tick();
    chk("cnt_63", {6'd0, frame_cnt}, 12'd63);
    frame_tick();
    chk("cnt_wrap", {6'd0, frame_cnt}, 12'd0);
    chk("wrap_fs", {11'd0, frame_start}, 12'd1);
    tick();
    tick();
    chk("refill_rgb", rgb, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_renderer.md
SNAKE_RENDERER -- requirements
Module: snake_renderer

Interface
REQ-001 Parameter CELL_SHIFT, default 4, log2 of cell size in pixels (16x16 cells).
REQ-002 Parameter GRID_W, default 40, grid columns.
REQ-003 Parameter GRID_H, default 30, grid rows.
REQ-004 Port i_clk  input  1  system clock, 100 MHz; the only clock.
REQ-005 Port i_resetn  input  1  reset, synchronous, active-low.
REQ-006 Port i_pix_tick  input  1  pixel enable, one i_clk cycle high every 4 cycles.
REQ-007 Port i_hcount  input  10  current pixel column from the timing generator.
REQ-008 Port i_vcount  input  10  current pixel row from the timing generator.
REQ-009 Port i_hsync, i_vsync  input  1 each  sync from the timing generator, active-low.
REQ-010 Port i_video_on  input  1  high inside the 640x480 visible area.
REQ-011 Port i_game_over  input  1  game-over flag, level-sensitive.
REQ-012 Port o_cell_addr  output  11  board RAM read address, row*GRID_W+col.
REQ-013 Port i_cell_data  input  2  board RAM read data, valid 1 i_clk after o_cell_addr changes: 0 empty, 1 body, 2 head, 3 food.
REQ-014 Port o_rgb  output  12  pixel colour {R[3:0],G[3:0],B[3:0]}.
REQ-015 Port o_hsync, o_vsync  output  1 each  syncs delayed to align with o_rgb.
REQ-016 Port o_frame_start  output  1  one-i_clk pulse at the start of each frame.
REQ-017 Port o_frame_cnt  output  6  free-running frame counter.

Function
REQ-018 All pipeline registers SHALL advance only on i_clk edges where i_pix_tick=1; otherwise they hold.
REQ-019 Stage 1 SHALL register col=i_hcount>>CELL_SHIFT, row=i_vcount>>CELL_SHIFT, o_cell_addr=(row<<5)+(row<<3)+col (GRID_W=40), and delayed i_video_on, i_hsync, i_vsync, edge flag.
REQ-020 When i_video_on=0, stage 1 SHALL drive o_cell_addr=0.
REQ-021 Edge flag SHALL be 1 when row=0, row=GRID_H-1, col=0 or col=GRID_W-1.
REQ-022 Stage 2 SHALL register o_rgb from i_cell_data plus the stage-1 flags; o_hsync/o_vsync SHALL be the stage-1 syncs, giving a total latency of exactly 2 pix_ticks for rgb and syncs.
REQ-023 Colour map: empty 0x000 (0x888 if edge flag); body 0x0F0; head 0xFF0; food 0xF00.
REQ-024 Food blink: when o_frame_cnt[4]=1, food SHALL render as empty (edge rule still applies).
REQ-025 When i_game_over=1, body and head SHALL render 0xF00 and 0xF0F respectively; other colours unchanged.
REQ-026 When the delayed video_on=0, o_rgb SHALL be 0x000 regardless of i_cell_data.
REQ-027 On a pix_tick with i_hcount=0 and i_vcount=0, o_frame_start SHALL be 1 for the following i_clk cycle only, and o_frame_cnt SHALL increment on the same edge.
REQ-028 o_frame_cnt SHALL wrap 63 -> 0 with no other effect.
REQ-029 Addresses SHALL never exceed GRID_W*GRID_H-1 (1199) for in-range counts; out-of-range inputs while video_on=0 SHALL yield address 0.

Reset
REQ-030 While i_resetn=0 at an i_clk edge: o_rgb=0x000, o_hsync=1, o_vsync=1, o_cell_addr=0, o_frame_start=0, o_frame_cnt=0, all pipeline flags cleared.
REQ-031 Reset asserted mid-line or mid-frame SHALL take effect at the next i_clk edge independent of i_pix_tick; the pipeline refills normally after release.

Verification
REQ-032 Pixel (h=17,v=33), video_on=1, RAM returns 1 -> o_cell_addr=81; o_rgb=0x0F0 two pix_ticks later.
REQ-033 Pixel (h=0,v=0), RAM returns 0 -> edge colour 0x888; o_frame_start pulses one i_clk cycle; o_frame_cnt 0->1.
REQ-034 Food (data=3) at cell (5,5) over 32 frames -> 0xF00 for frames with cnt[4]=0, 0x000 when cnt[4]=1.
REQ-035 i_game_over=1, head cell -> 0xF0F; body cell -> 0xF00; video_on=0 with data=2 -> 0x000.
REQ-036 i_hsync toggled low at tick N -> o_hsync low at tick N+2; i_pix_tick held 0 -> all outputs hold.
REQ-037 i_resetn=0 mid-frame with o_frame_cnt=37 -> next edge all outputs at REQ-030 values; frame 63 then frame start -> cnt=0.
